hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage KLP32 core (fetch, decode, execute, memory, writeback).
- Keeps a shadow record of in-flight instructions (destination register, write enable, load flag, source usage) for the execute, memory and writeback stages.
- From that record it generates fetch/decode stalls, flushes and bubbles, forwarding selects for the execute operands, and stall/flush performance counters.

Parameters:
- XLEN, 32, width of the instruction word and of the counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_decode_inst  in  XLEN  instruction in decode (rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0]).
- i_decode_valid  in  1  decode holds a real instruction.
- i_decode_reg_wr_en  in  1  decode control: instruction writes rd.
- i_decode_wb_sel  in  2  decode control: 2'b00 means writeback from memory (load).
- i_ex_pc_sel  in  1  execute resolved a taken branch or jump.
- i_mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- o_fetch_stall  out  1  hold PC and the fetch/decode register.
- o_decode_stall  out  1  hold the decode/execute inputs.
- o_fetch_flush  out  1  kill the instruction entering decode.
- o_decode_flush  out  1  insert a bubble into execute.
- o_fwd_a_sel  out  2  execute operand A: 00 regfile, 01 memory-stage result, 10 writeback value.
- o_fwd_b_sel  out  2  execute operand B, same encoding.
- o_stall_cycles  out  XLEN  count of cycles with o_fetch_stall=1.
- o_flush_count  out  XLEN  count of taken-redirect flushes.

Behaviour:
- Source usage by opcode:
  - rs1 is used unless opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
  - rs2 is used only for 0110011, 0100011 and 1100011.
- Shadow entries EX, MEM and WB each hold {valid, rd, wr_en, is_load, rs1, rs2, use_rs1, use_rs2}.
- Reset: all entries have valid=0 and both counters are 0. All outputs are 0 in the cycle after reset.
- Hazard when EX is a load: EX.valid & EX.is_load & EX.rd!=0 & i_decode_valid, and EX.rd equals a used decode source register.
- Priority, evaluated combinationally each cycle:
  1. i_mem_busy=1: fetch_stall=decode_stall=1, no flush, all entries hold. Counters: stall_cycles increments; flush_count does not.
  2. i_ex_pc_sel=1: fetch_flush=decode_flush=1, stalls=0, flush_count increments. Shift MEM<=EX and WB<=MEM; EX becomes a bubble.
  3. Load-use hazard: fetch_stall=decode_stall=1 and decode_flush=1 for exactly one cycle; stall_cycles increments. Shift MEM<=EX and WB<=MEM; EX becomes a bubble. The next cycle re-evaluates with the load in MEM, so there is no hazard.
  4. Otherwise: no stall or flush. Shift normally; EX captures the decode fields with valid=i_decode_valid.
- The branch stays in execute while the memory stage is busy, so i_ex_pc_sel stays asserted and the redirect is taken on the first non-busy cycle.
- Forwarding is combinational from the registered entries, with zero latency:
  - Select 01 if MEM.valid & MEM.wr_en & !MEM.is_load & MEM.rd!=0 & MEM.rd==EX.rsN & EX.use_rsN.
  - Else select 10 if the same test passes on WB (loads allowed).
  - Else select 00. MEM has priority over WB. x0 is never forwarded.
- When EX.valid=0, both forwarding selects are 00.
- Counters wrap modulo 2^XLEN.
- Reset asserted mid-operation clears all entries and counters on the next edge; no stall or flush is held over.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0; stall_cycles=0 and flush_count=0.
- Sequence 0x00400793 (addi x15,x0,4), 0x00500513 (addi x10,x0,5), 0x40F50533 (sub x10,x10,x15) -> with sub in EX: fwd_a_sel=01, fwd_b_sel=10, no stall.
- Sequence 0x0000A283 (lw x5,0(x1)) then 0x00728333 (add x6,x5,x7) -> one cycle with fetch_stall=decode_stall=decode_flush=1 and stall_cycles=1. Then with add in EX: fwd_a_sel=10, fwd_b_sel=00.
- Pulse i_ex_pc_sel=1 for one cycle during a normal stream -> fetch_flush=decode_flush=1 in that cycle only; flush_count=1; the next EX entry has valid=0 and forwarding 00.
- i_mem_busy=1 for 3 cycles while i_ex_pc_sel=1 and a load-use hazard is present -> stalls=1 and no flush for 3 cycles (stall_cycles +3). The flush happens on the 4th cycle, flush_count +1, and the load-use stall is superseded.
- Write to x0 (0x00000013 then an add reading x0) -> fwd selects stay 00 and no stall.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode-side controls and pipeline status in, stall/flush/forwarding
// controls and performance counters out.
//   master : core pipeline side (drives decode/execute/memory status, receives controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] i_decode_inst;
    logic            i_decode_valid;
    logic            i_decode_reg_wr_en;
    logic [1:0]      i_decode_wb_sel;
    logic            i_ex_pc_sel;
    logic            i_mem_busy;

    logic            o_fetch_stall;
    logic            o_decode_stall;
    logic            o_fetch_flush;
    logic            o_decode_flush;
    logic [1:0]      o_fwd_a_sel;
    logic [1:0]      o_fwd_b_sel;
    logic [XLEN-1:0] o_stall_cycles;
    logic [XLEN-1:0] o_flush_count;

    modport master (
        output i_decode_inst, i_decode_valid, i_decode_reg_wr_en, i_decode_wb_sel,
        output i_ex_pc_sel, i_mem_busy,
        input  o_fetch_stall, o_decode_stall, o_fetch_flush, o_decode_flush,
        input  o_fwd_a_sel, o_fwd_b_sel, o_stall_cycles, o_flush_count
    );

    modport slave (
        input  i_decode_inst, i_decode_valid, i_decode_reg_wr_en, i_decode_wb_sel,
        input  i_ex_pc_sel, i_mem_busy,
        output o_fetch_stall, o_decode_stall, o_fetch_flush, o_decode_flush,
        output o_fwd_a_sel, o_fwd_b_sel, o_stall_cycles, o_flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage KLP32 core.
// Tracks a shadow record of the instructions in execute, memory and writeback and derives
// stalls, flushes, bubbles, execute-operand forwarding selects and stall/flush counters.
// Ports:
//   clk   - core clock, all state updates on the rising edge
//   reset - synchronous active-high reset
//   bus   - hazard_ctrl_if slave: decode instruction/controls, redirect and memory-busy in;
//           fetch/decode stall and flush, forwarding selects and counters out
module hazard_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } entry_t;

    entry_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, dec_entry;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [6:0]      dec_opcode;
    logic            load_use;

    assign dec_opcode = bus.i_decode_inst[6:0];

    always_comb begin
        dec_entry.valid   = bus.i_decode_valid;
        dec_entry.rd      = bus.i_decode_inst[11:7];
        dec_entry.wr_en   = bus.i_decode_reg_wr_en;
        dec_entry.is_load = (bus.i_decode_wb_sel == 2'b00);
        dec_entry.rs1     = bus.i_decode_inst[19:15];
        dec_entry.rs2     = bus.i_decode_inst[24:20];
        dec_entry.use_rs1 = !((dec_opcode == OpLui) || (dec_opcode == OpAuipc) ||
                              (dec_opcode == OpJal));
        dec_entry.use_rs2 = (dec_opcode == OpReg) || (dec_opcode == OpStore) ||
                            (dec_opcode == OpBranch);
    end

    // Load result is not available until MEM completes, so a consumer in decode must wait.
    assign load_use = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && bus.i_decode_valid &&
                      ((dec_entry.use_rs1 && (dec_entry.rs1 == ex_q.rd)) ||
                       (dec_entry.use_rs2 && (dec_entry.rs2 == ex_q.rd)));

    always_comb begin
        bus.o_fetch_stall  = 1'b0;
        bus.o_decode_stall = 1'b0;
        bus.o_fetch_flush  = 1'b0;
        bus.o_decode_flush = 1'b0;
        ex_d               = ex_q;
        mem_d              = mem_q;
        wb_d               = wb_q;
        stall_cnt_d        = stall_cnt_q;
        flush_cnt_d        = flush_cnt_q;
        if (bus.i_mem_busy) begin
            // Whole pipeline frozen; a pending redirect waits for the first free cycle.
            bus.o_fetch_stall  = 1'b1;
            bus.o_decode_stall = 1'b1;
            stall_cnt_d        = stall_cnt_q + XLEN'(1);
        end else if (bus.i_ex_pc_sel) begin
            bus.o_fetch_flush  = 1'b1;
            bus.o_decode_flush = 1'b1;
            flush_cnt_d        = flush_cnt_q + XLEN'(1);
            wb_d               = mem_q;
            mem_d              = ex_q;
            ex_d               = '0;
        end else if (load_use) begin
            bus.o_fetch_stall  = 1'b1;
            bus.o_decode_stall = 1'b1;
            bus.o_decode_flush = 1'b1;
            stall_cnt_d        = stall_cnt_q + XLEN'(1);
            wb_d               = mem_q;
            mem_d              = ex_q;
            ex_d               = '0;
        end else begin
            wb_d               = mem_q;
            mem_d              = ex_q;
            ex_d               = dec_entry;
        end
    end

    // Loads in MEM have no data yet, so only WB may forward a load result.
    function automatic logic fwd_hit(entry_t src, logic [4:0] rs, logic use_rs,
                                     logic allow_load);
        return src.valid && src.wr_en && (allow_load || !src.is_load) &&
               (src.rd != 5'd0) && (src.rd == rs) && use_rs;
    endfunction

    always_comb begin
        bus.o_fwd_a_sel = 2'b00;
        bus.o_fwd_b_sel = 2'b00;
        if (ex_q.valid) begin
            if (fwd_hit(mem_q, ex_q.rs1, ex_q.use_rs1, 1'b0)) begin
                bus.o_fwd_a_sel = 2'b01;
            end else if (fwd_hit(wb_q, ex_q.rs1, ex_q.use_rs1, 1'b1)) begin
                bus.o_fwd_a_sel = 2'b10;
            end
            if (fwd_hit(mem_q, ex_q.rs2, ex_q.use_rs2, 1'b0)) begin
                bus.o_fwd_b_sel = 2'b01;
            end else if (fwd_hit(wb_q, ex_q.rs2, ex_q.use_rs2, 1'b1)) begin
                bus.o_fwd_b_sel = 2'b10;
            end
        end
    end

    assign bus.o_stall_cycles = stall_cnt_q;
    assign bus.o_flush_count  = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // WB source fields and the funct fields of the instruction are never consulted.
    logic unused_bits;
    assign unused_bits = ^{wb_q, bus.i_decode_inst[XLEN-1:25], bus.i_decode_inst[14:12]};
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.XLEN(32)) bus ();
    hazard_ctrl #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: in-flight instructions kept as raw words, decoded on demand.
    typedef struct {
        bit        valid;
        bit [31:0] inst;
        bit        wr;
        bit        ld;
    } rec_t;

    rec_t      m_ex, m_mem, m_wb;
    bit [31:0] m_stall, m_flush;

    function automatic bit [4:0] f_rd(bit [31:0] i);  return i[11:7];  endfunction
    function automatic bit [4:0] f_rs1(bit [31:0] i); return i[19:15]; endfunction
    function automatic bit [4:0] f_rs2(bit [31:0] i); return i[24:20]; endfunction
    function automatic bit uses1(bit [31:0] i);
        return !(i[6:0] == 7'b0110111 || i[6:0] == 7'b0010111 || i[6:0] == 7'b1101111);
    endfunction
    function automatic bit uses2(bit [31:0] i);
        return i[6:0] == 7'b0110011 || i[6:0] == 7'b0100011 || i[6:0] == 7'b1100011;
    endfunction

    function automatic bit m_hazard();
        bit [31:0] di;
        bit [4:0]  r;
        di = bus.i_decode_inst;
        r  = f_rd(m_ex.inst);
        if (!(m_ex.valid && m_ex.ld && r != 0 && bus.i_decode_valid)) return 1'b0;
        return (uses1(di) && f_rs1(di) == r) || (uses2(di) && f_rs2(di) == r);
    endfunction

    function automatic bit [1:0] m_fwd(bit [4:0] src, bit used);
        if (!m_ex.valid || !used || src == 0) return 2'b00;
        if (m_mem.valid && m_mem.wr && !m_mem.ld && f_rd(m_mem.inst) == src) return 2'b01;
        if (m_wb.valid && m_wb.wr && f_rd(m_wb.inst) == src) return 2'b10;
        return 2'b00;
    endfunction

    // {fetch_stall, decode_stall, fetch_flush, decode_flush, fwd_a, fwd_b}
    function automatic bit [7:0] m_outs();
        bit fs, ds, ff, df;
        fs = 0; ds = 0; ff = 0; df = 0;
        if (bus.i_mem_busy) begin
            fs = 1; ds = 1;
        end else if (bus.i_ex_pc_sel) begin
            ff = 1; df = 1;
        end else if (m_hazard()) begin
            fs = 1; ds = 1; df = 1;
        end
        return {fs, ds, ff, df, m_fwd(f_rs1(m_ex.inst), uses1(m_ex.inst)),
                m_fwd(f_rs2(m_ex.inst), uses2(m_ex.inst))};
    endfunction

    function automatic bit [7:0] got();
        return {bus.o_fetch_stall, bus.o_decode_stall, bus.o_fetch_flush, bus.o_decode_flush,
                bus.o_fwd_a_sel, bus.o_fwd_b_sel};
    endfunction

    task automatic set_in(input bit [31:0] inst, input bit dv, input bit wr, input bit [1:0] ws,
                          input bit pc, input bit busy);
        bus.i_decode_inst      = inst;
        bus.i_decode_valid     = dv;
        bus.i_decode_reg_wr_en = wr;
        bus.i_decode_wb_sel    = ws;
        bus.i_ex_pc_sel        = pc;
        bus.i_mem_busy         = busy;
        #1;
    endtask

    // Advance the model using the inputs presented this cycle, then let the DUT clock.
    task automatic tick();
        bit   hz;
        rec_t bubble;
        bubble = '{valid: 0, inst: 0, wr: 0, ld: 0};
        hz = m_hazard();
        if (reset) begin
            m_ex = bubble; m_mem = bubble; m_wb = bubble;
            m_stall = 0; m_flush = 0;
        end else if (bus.i_mem_busy) begin
            m_stall = m_stall + 1;
        end else begin
            if (bus.i_ex_pc_sel) m_flush = m_flush + 1;
            else if (hz) m_stall = m_stall + 1;
            m_wb  = m_mem;
            m_mem = m_ex;
            if (bus.i_ex_pc_sel || hz) m_ex = bubble;
            else m_ex = '{valid: bus.i_decode_valid, inst: bus.i_decode_inst,
                          wr: bus.i_decode_reg_wr_en, ld: (bus.i_decode_wb_sel == 2'b00)};
        end
        @(posedge clk);
        #1;
    endtask

    localparam bit [31:0] AddiX15 = 32'h00400793;
    localparam bit [31:0] AddiX10 = 32'h00500513;
    localparam bit [31:0] SubX10  = 32'h40F50533;
    localparam bit [31:0] LwX5    = 32'h0000A283;
    localparam bit [31:0] AddX6   = 32'h00728333;
    localparam bit [31:0] NopX0   = 32'h00000013;
    localparam bit [31:0] AddX0s  = 32'h00000333;

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 2'b01, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (got() !== 8'h00) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected %b", got(), 8'h00);
        end
        n_cmp++;
        if (bus.o_stall_cycles !== 32'd0) begin
            n_bad++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.o_stall_cycles);
        end
        n_cmp++;
        if (bus.o_flush_count !== 32'd0) begin
            n_bad++; $display("FAIL reset_flush_cnt: got %0d expected 0", bus.o_flush_count);
        end
    endtask

    task automatic test_forward();
        set_in(AddiX15, 1, 1, 2'b01, 0, 0);
        tick();
        set_in(AddiX10, 1, 1, 2'b01, 0, 0);
        tick();
        set_in(SubX10, 1, 1, 2'b01, 0, 0);
        n_cmp++;
        if (got() !== m_outs()) begin
            n_bad++; $display("FAIL fwd_sub_decode: got %b expected %b", got(), m_outs());
        end
        tick();
        set_in(0, 0, 0, 2'b01, 0, 0);
        n_cmp++;
        if (got() !== 8'b0000_01_10) begin
            n_bad++; $display("FAIL fwd_sub_ex: got %b expected %b", got(), 8'b0000_01_10);
        end
    endtask

    task automatic test_load_use();
        bit [31:0] sbase;
        set_in(LwX5, 1, 1, 2'b00, 0, 0);
        tick();
        set_in(AddX6, 1, 1, 2'b01, 0, 0);
        sbase = bus.o_stall_cycles;
        n_cmp++;
        if (got() !== 8'b1101_00_00) begin
            n_bad++; $display("FAIL load_use_stall: got %b expected %b", got(), 8'b1101_00_00);
        end
        tick();
        n_cmp++;
        if (bus.o_stall_cycles !== sbase + 1) begin
            n_bad++;
            $display("FAIL load_use_cnt: got %0d expected %0d", bus.o_stall_cycles, sbase + 1);
        end
        n_cmp++;
        if (got() !== 8'h00) begin
            n_bad++; $display("FAIL load_use_release: got %b expected %b", got(), 8'h00);
        end
        tick();
        set_in(0, 0, 0, 2'b01, 0, 0);
        n_cmp++;
        if (got() !== 8'b0000_10_00) begin
            n_bad++; $display("FAIL load_use_fwd: got %b expected %b", got(), 8'b0000_10_00);
        end
    endtask

    task automatic test_redirect();
        bit [31:0] fbase;
        set_in(AddiX15, 1, 1, 2'b01, 0, 0);
        tick();
        set_in(AddiX10, 1, 1, 2'b01, 1, 0);
        fbase = bus.o_flush_count;
        n_cmp++;
        if (got() !== 8'b0011_00_00) begin
            n_bad++; $display("FAIL redirect_flush: got %b expected %b", got(), 8'b0011_00_00);
        end
        tick();
        set_in(AddiX10, 1, 1, 2'b01, 0, 0);
        n_cmp++;
        if (got() !== 8'h00) begin
            n_bad++; $display("FAIL redirect_after: got %b expected %b", got(), 8'h00);
        end
        n_cmp++;
        if (bus.o_flush_count !== fbase + 1) begin
            n_bad++;
            $display("FAIL redirect_cnt: got %0d expected %0d", bus.o_flush_count, fbase + 1);
        end
    endtask

    task automatic test_busy_redirect();
        bit [31:0] sbase, fbase;
        set_in(LwX5, 1, 1, 2'b00, 0, 0);
        tick();
        set_in(AddX6, 1, 1, 2'b01, 1, 1);
        sbase = bus.o_stall_cycles;
        fbase = bus.o_flush_count;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got() !== 8'b1100_00_00) begin
                n_bad++;
                $display("FAIL busy_hold[%0d]: got %b expected %b", i, got(), 8'b1100_00_00);
            end
            tick();
        end
        set_in(AddX6, 1, 1, 2'b01, 1, 0);
        n_cmp++;
        if (got() !== 8'b0011_00_00) begin
            n_bad++; $display("FAIL busy_then_flush: got %b expected %b", got(), 8'b0011_00_00);
        end
        tick();
        n_cmp++;
        if (bus.o_stall_cycles !== sbase + 3) begin
            n_bad++;
            $display("FAIL busy_stall_cnt: got %0d expected %0d", bus.o_stall_cycles, sbase + 3);
        end
        n_cmp++;
        if (bus.o_flush_count !== fbase + 1) begin
            n_bad++;
            $display("FAIL busy_flush_cnt: got %0d expected %0d", bus.o_flush_count, fbase + 1);
        end
    endtask

    task automatic test_x0();
        set_in(0, 0, 0, 2'b01, 0, 0);
        tick();
        set_in(NopX0, 1, 1, 2'b01, 0, 0);
        tick();
        set_in(AddX0s, 1, 1, 2'b01, 0, 0);
        n_cmp++;
        if (got() !== 8'h00) begin
            n_bad++; $display("FAIL x0_no_stall: got %b expected %b", got(), 8'h00);
        end
        tick();
        set_in(0, 0, 0, 2'b01, 0, 0);
        n_cmp++;
        if (got() !== 8'h00) begin
            n_bad++; $display("FAIL x0_no_fwd: got %b expected %b", got(), 8'h00);
        end
    endtask

    task automatic test_random();
        bit [6:0]  ops [8];
        bit [6:0]  op;
        bit [31:0] inst;
        bit        ld;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        for (int c = 0; c < 400; c++) begin
            op   = ops[$urandom_range(0, 7)];
            inst = {7'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b000,
                    5'($urandom_range(0, 3)), op};
            ld   = (op == 7'b0000011);
            reset = ($urandom_range(0, 59) == 0);
            set_in(inst, $urandom_range(0, 3) != 0,
                   !(op == 7'b0100011 || op == 7'b1100011), ld ? 2'b00 : 2'b01,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            n_cmp++;
            if (got() !== m_outs()) begin
                n_bad++; $display("FAIL rand_outs[%0d]: got %b expected %b", c, got(), m_outs());
            end
            n_cmp++;
            if (bus.o_stall_cycles !== m_stall || bus.o_flush_count !== m_flush) begin
                n_bad++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", c,
                         bus.o_stall_cycles, bus.o_flush_count, m_stall, m_flush);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        m_ex    = '{valid: 0, inst: 0, wr: 0, ld: 0};
        m_mem   = m_ex;
        m_wb    = m_ex;
        m_stall = 0;
        m_flush = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_redirect();
        test_busy_redirect();
        test_x0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
